// File: rtl/riscv_bus_arbiter.sv
// Two-master bus arbiter: instruction fetch and data port share one memory port,
// one transaction in flight, round-robin between masters, sticky timeout error.
module riscv_bus_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        bus_err,
   output logic [1:0]  dbg_state_o
);

   // Handshake: a master holds req with its command stable; the single-cycle gnt
   // accepts it, and the owner's rvalid pulses one cycle after mem_ack.
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_BUSY_IF = 2'd1;
   localparam logic [1:0] S_BUSY_D  = 2'd2;
   localparam logic [1:0] S_ERR     = 2'd3;

   localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rr_data_q, rr_data_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic [3:0]    mem_be_q, mem_be_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          if_rvalid_q, if_rvalid_d;
   logic          d_rvalid_q, d_rvalid_d;
   logic          bus_err_q, bus_err_d;
   logic          if_win, d_win;

   // rr_data_q = 1 means the data port wins a simultaneous request.
   always_comb begin
      if_win = 1'b0;
      d_win  = 1'b0;
      if (!rst && state_q == S_IDLE) begin
         if (if_req && d_req) begin
            if (rr_data_q) d_win = 1'b1;
            else           if_win = 1'b1;
         end else if (if_req) begin
            if_win = 1'b1;
         end else if (d_req) begin
            d_win = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rr_data_d   = rr_data_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      rdata_d     = rdata_q;
      if_rvalid_d = 1'b0;
      d_rvalid_d  = 1'b0;
      bus_err_d   = bus_err_q;
      case (state_q)
         S_IDLE: begin
            if (d_win) begin
               state_d     = S_BUSY_D;
               mem_req_d   = 1'b1;
               mem_we_d    = d_we;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               mem_be_d    = d_be;
               cnt_d       = '0;
               rr_data_d   = 1'b0;
            end else if (if_win) begin
               state_d     = S_BUSY_IF;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wdata_d = 32'h0;
               mem_be_d    = 4'hF;
               cnt_d       = '0;
               rr_data_d   = 1'b1;
            end
         end
         S_BUSY_IF, S_BUSY_D: begin
            // An ack on the final allowed cycle still completes normally.
            if (mem_ack) begin
               state_d     = S_IDLE;
               mem_req_d   = 1'b0;
               rdata_d     = mem_rdata;
               if_rvalid_d = (state_q == S_BUSY_IF);
               d_rvalid_d  = (state_q == S_BUSY_D);
            end else if (cnt_q == TO_LAST) begin
               state_d   = S_ERR;
               mem_req_d = 1'b0;
               bus_err_d = 1'b1;
               cnt_d     = cnt_q + CW'(1);
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            mem_req_d = 1'b0;
            bus_err_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rr_data_q   <= 1'b1;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         mem_be_q    <= 4'h0;
         rdata_q     <= 32'h0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rr_data_q   <= rr_data_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         rdata_q     <= rdata_d;
         if_rvalid_q <= if_rvalid_d;
         d_rvalid_q  <= d_rvalid_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign if_gnt      = if_win;
   assign d_gnt       = d_win;
   assign if_rvalid   = if_rvalid_q;
   assign d_rvalid    = d_rvalid_q;
   assign rdata       = rdata_q;
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_be      = mem_be_q;
   assign bus_err     = bus_err_q;
   assign dbg_state_o = state_q;

endmodule
